// File: rtl/viterbi_pkg.sv
// Shared constants and state encoding for the Viterbi front-end frame controller.
package viterbi_pkg;

  localparam int SYM_W        = 2;
  localparam int SYM_PER_WORD = 8;
  localparam int WORD_W       = SYM_W * SYM_PER_WORD;
  localparam int LEN_W        = 12;
  localparam int SEL_W        = $clog2(SYM_PER_WORD);
  // Wide enough for 8 * (2^LEN_W - 1) steps, so step_cnt never wraps
  localparam int STEP_W       = LEN_W + SEL_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_TB   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/viterbi_frame_ctrl_if.sv
// Frame-control bus: word input handshake, shifter/ACS sequencing and traceback strobes.
interface viterbi_frame_ctrl_if;
  import viterbi_pkg::*;

  logic              frame_start;
  logic [LEN_W-1:0]  frame_len;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              sh_load;
  logic [WORD_W-1:0] sh_data;
  logic              acs_en;
  logic [SEL_W-1:0]  sym_sel;
  logic              acs_first;
  logic              acs_last;
  logic [STEP_W-1:0] step_cnt;
  logic              tb_start;
  logic              tb_done;
  logic              frame_done;
  logic              busy;
  logic              len_err;

  // master is the controller, slave is the surrounding front end
  modport master (
    input  frame_start, frame_len, in_valid, in_data, tb_done,
    output in_ready, sh_load, sh_data, acs_en, sym_sel, acs_first, acs_last,
           step_cnt, tb_start, frame_done, busy, len_err
  );

  modport slave (
    output frame_start, frame_len, in_valid, in_data, tb_done,
    input  in_ready, sh_load, sh_data, acs_en, sym_sel, acs_first, acs_last,
           step_cnt, tb_start, frame_done, busy, len_err
  );

endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer: loads received words into the shifter, steps the ACS through each
// word's symbols, then triggers traceback and reports frame completion.
module viterbi_frame_ctrl
  import viterbi_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  viterbi_frame_ctrl_if.master bus
);

  localparam logic [SEL_W-1:0] SYM_LAST = SEL_W'(SYM_PER_WORD - 1);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  words_left_q, words_left_d;
  logic [WORD_W-1:0] sh_data_q, sh_data_d;
  logic [SEL_W-1:0]  sym_sel_q, sym_sel_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic              first_q, first_d;
  logic              tb_start_q, tb_start_d;

  logic in_ready;
  logic sh_load;
  logic acs_en;
  logic acs_last;
  logic len_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      words_left_q <= '0;
      sh_data_q    <= '0;
      sym_sel_q    <= '0;
      step_cnt_q   <= '0;
      first_q      <= 1'b0;
      tb_start_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      sh_data_q    <= sh_data_d;
      sym_sel_q    <= sym_sel_d;
      step_cnt_q   <= step_cnt_d;
      first_q      <= first_d;
      tb_start_q   <= tb_start_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    sh_data_d    = sh_data_q;
    sym_sel_d    = sym_sel_q;
    step_cnt_d   = step_cnt_q;
    first_d      = first_q;
    tb_start_d   = 1'b0;
    in_ready     = 1'b0;
    sh_load      = 1'b0;
    acs_en       = 1'b0;
    acs_last     = 1'b0;
    len_err      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.frame_start) begin
          if (bus.frame_len != '0) begin
            words_left_d = bus.frame_len;
            step_cnt_d   = '0;
            first_d      = 1'b1;
            state_d      = ST_LOAD;
          end else begin
            len_err = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          sh_load      = 1'b1;
          sh_data_d    = bus.in_data;
          words_left_d = words_left_q - LEN_W'(1);
          sym_sel_d    = '0;
          state_d      = ST_RUN;
        end
      end

      ST_RUN: begin
        acs_en     = 1'b1;
        first_d    = 1'b0;
        sym_sel_d  = sym_sel_q + SEL_W'(1);
        step_cnt_d = step_cnt_q + STEP_W'(1);
        // On the last symbol, fetch the next word without a bubble or finish the frame
        if (sym_sel_q == SYM_LAST) begin
          if (words_left_q != '0) begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
              sh_load      = 1'b1;
              sh_data_d    = bus.in_data;
              words_left_d = words_left_q - LEN_W'(1);
              sym_sel_d    = '0;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            acs_last   = 1'b1;
            tb_start_d = 1'b1;
            state_d    = ST_TB;
          end
        end
      end

      ST_TB: begin
        if (bus.tb_done) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready   = in_ready;
  assign bus.sh_load    = sh_load;
  assign bus.sh_data    = sh_data_q;
  assign bus.acs_en     = acs_en;
  assign bus.sym_sel    = sym_sel_q;
  assign bus.acs_first  = acs_en & first_q;
  assign bus.acs_last   = acs_last;
  assign bus.step_cnt   = step_cnt_q;
  assign bus.tb_start   = tb_start_q;
  assign bus.frame_done = (state_q == ST_DONE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.len_err    = len_err;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed, table-driven bench for viterbi_frame_ctrl: whole frames with stalls and
// traceback delays, plus hand-written reset, zero-length and mid-frame-reset sequences.
module tb_viterbi_frame_ctrl;
  import viterbi_pkg::*;

  typedef struct {
    string       tag;
    int          len;
    int          stall;
    int          tb_delay;
    int          noise;
    logic [15:0] seed;
    int          exp_loads;
    int          exp_acs;
    int          exp_step;
    int          exp_gap;
    int          exp_cycles;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[6];

  always #5 clk = ~clk;

  viterbi_frame_ctrl_if bus ();

  viterbi_frame_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [15:0] seed, input int idx);
    return seed + 16'(idx) * 16'h0101;
  endfunction

  // Runs one frame from a negedge, driving inputs per cycle and scoring the outputs
  task automatic applyStimulus(input vec_t v);
    int          word_idx = 0, load_wait = 0, cyc = 0, tb_cnt = 0;
    bit          in_tb = 0, seen_done = 0;
    int          n_load = 0, n_acs = 0, n_first = 0, n_last = 0, n_tbs = 0, n_done = 0;
    int          n_lenerr = 0, gap = 0, sym_bad = 0, data_bad = 0, lat_bad = 0, busy_bad = 0;
    int          exp_sym = 0, first_pos = -1, last_pos = -1, step_at_tb = -1;
    bit          prev_load = 0;
    logic [15:0] cur_word = '0;

    while (!seen_done && cyc < 2000) begin
      bus.frame_start = (cyc == 0);
      bus.frame_len   = (cyc == 0) ? LEN_W'(v.len) : '0;
      if (v.noise != 0 && bus.acs_en && bus.sym_sel == 3'd3) begin
        bus.frame_start = 1'b1;
        bus.frame_len   = LEN_W'(7);
      end
      if (v.noise != 0 && bus.acs_en && bus.sym_sel == 3'd5) begin
        bus.frame_start = 1'b1;
        bus.frame_len   = '0;
      end

      if (bus.tb_start) begin
        in_tb  = 1;
        tb_cnt = 0;
      end
      bus.tb_done = (in_tb && tb_cnt == v.tb_delay) ||
                    (v.noise != 0 && bus.acs_en && bus.sym_sel == 3'd2);
      if (in_tb) tb_cnt++;

      if (word_idx == 1 && v.stall > 0 && bus.in_ready && !bus.acs_en) load_wait++;
      bus.in_valid = (word_idx < v.len) && !(word_idx == 1 && v.stall > 0 && load_wait < v.stall);
      bus.in_data  = (word_idx < v.len) ? word_of(v.seed, word_idx) : 16'hDEAD;
      #1;

      if (bus.sh_load) n_load++;
      if (bus.acs_en) begin
        n_acs++;
        if (bus.sym_sel !== 3'(exp_sym)) sym_bad++;
        exp_sym = (exp_sym + 1) % 8;
        if (bus.sh_data !== cur_word) data_bad++;
      end
      if (bus.acs_first) begin n_first++; first_pos = n_acs; end
      if (bus.acs_last)  begin n_last++;  last_pos  = n_acs; end
      if (prev_load && !bus.acs_en) lat_bad++;
      if (bus.in_ready && !bus.acs_en && n_acs > 0) gap++;
      if (bus.tb_start) begin n_tbs++; step_at_tb = int'(bus.step_cnt); end
      if (bus.frame_done) begin n_done++; seen_done = 1; end
      if (bus.len_err) n_lenerr++;
      if (cyc > 0 && !bus.busy) busy_bad++;
      prev_load = bus.sh_load;
      if (bus.in_valid && bus.in_ready) begin
        cur_word = bus.in_data;
        word_idx++;
        exp_sym  = 0;
      end
      cyc++;
      @(negedge clk);
    end

    bus.frame_start = 1'b0;
    bus.in_valid    = 1'b0;
    bus.tb_done     = 1'b0;
    #1;
    checkOutput({v.tag, ".done_seen"},  32'(seen_done), 32'd1);
    checkOutput({v.tag, ".cycles"},     32'(cyc),        32'(v.exp_cycles));
    checkOutput({v.tag, ".sh_loads"},   32'(n_load),     32'(v.exp_loads));
    checkOutput({v.tag, ".acs_en"},     32'(n_acs),      32'(v.exp_acs));
    checkOutput({v.tag, ".first_cnt"},  32'(n_first),    32'd1);
    checkOutput({v.tag, ".first_pos"},  32'(first_pos),  32'd1);
    checkOutput({v.tag, ".last_cnt"},   32'(n_last),     32'd1);
    checkOutput({v.tag, ".last_pos"},   32'(last_pos),   32'(v.exp_acs));
    checkOutput({v.tag, ".tb_start"},   32'(n_tbs),      32'd1);
    checkOutput({v.tag, ".step_at_tb"}, 32'(step_at_tb), 32'(v.exp_step));
    checkOutput({v.tag, ".frame_done"}, 32'(n_done),     32'd1);
    checkOutput({v.tag, ".len_err"},    32'(n_lenerr),   32'd0);
    checkOutput({v.tag, ".stall_gap"},  32'(gap),        32'(v.exp_gap));
    checkOutput({v.tag, ".sym_seq"},    32'(sym_bad),    32'd0);
    checkOutput({v.tag, ".sh_data"},    32'(data_bad),   32'd0);
    checkOutput({v.tag, ".load_lat"},   32'(lat_bad),    32'd0);
    checkOutput({v.tag, ".busy_hold"},  32'(busy_bad),   32'd0);
    checkOutput({v.tag, ".idle_busy"},  32'(bus.busy),   32'd0);
    checkOutput({v.tag, ".step_hold"},  32'(bus.step_cnt), 32'(v.exp_step));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //            tag          len stall tbd noise seed      loads acs step gap cycles
    vecs[0] = '{"single",     1,  0,    2,  0,    16'hA5C3, 1,    8,  8,   0,  14};
    vecs[1] = '{"b2b",        4,  0,    0,  0,    16'h1234, 4,    32, 32,  0,  36};
    vecs[2] = '{"starve",     3,  5,    0,  0,    16'h0F0F, 3,    24, 24,  5,  33};
    vecs[3] = '{"ignored",    2,  0,    1,  1,    16'hBEEF, 2,    16, 16,  0,  21};
    vecs[4] = '{"stall1",     2,  1,    3,  0,    16'h8001, 2,    16, 16,  1,  24};
    vecs[5] = '{"post_rst",   1,  0,    0,  0,    16'h5A5A, 1,    8,  8,   0,  12};

    rst_n           = 1'b0;
    bus.frame_start = 1'b0;
    bus.frame_len   = '0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.tb_done     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rst.in_ready",   32'(bus.in_ready),   32'd0);
    checkOutput("rst.sh_load",    32'(bus.sh_load),    32'd0);
    checkOutput("rst.sh_data",    32'(bus.sh_data),    32'd0);
    checkOutput("rst.acs_en",     32'(bus.acs_en),     32'd0);
    checkOutput("rst.sym_sel",    32'(bus.sym_sel),    32'd0);
    checkOutput("rst.acs_first",  32'(bus.acs_first),  32'd0);
    checkOutput("rst.acs_last",   32'(bus.acs_last),   32'd0);
    checkOutput("rst.step_cnt",   32'(bus.step_cnt),   32'd0);
    checkOutput("rst.tb_start",   32'(bus.tb_start),   32'd0);
    checkOutput("rst.frame_done", 32'(bus.frame_done), 32'd0);
    checkOutput("rst.busy",       32'(bus.busy),       32'd0);
    checkOutput("rst.len_err",    32'(bus.len_err),    32'd0);
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
    end

    // Zero-length request: len_err pulse, controller stays idle
    bus.frame_start = 1'b1;
    bus.frame_len   = '0;
    #1;
    checkOutput("zero.len_err", 32'(bus.len_err), 32'd1);
    checkOutput("zero.busy",    32'(bus.busy),    32'd0);
    @(negedge clk);
    bus.frame_start = 1'b0;
    #1;
    checkOutput("zero.len_err_clr", 32'(bus.len_err),  32'd0);
    checkOutput("zero.busy_after",  32'(bus.busy),     32'd0);
    checkOutput("zero.in_ready",    32'(bus.in_ready), 32'd0);
    @(negedge clk);

    // Reset in the middle of a 4-word frame abandons it
    bus.frame_start = 1'b1;
    bus.frame_len   = LEN_W'(4);
    bus.in_valid    = 1'b1;
    bus.in_data     = 16'hC0DE;
    @(negedge clk);
    bus.frame_start = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    checkOutput("midrst.running", 32'(bus.acs_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.busy",     32'(bus.busy),     32'd0);
    checkOutput("midrst.acs_en",   32'(bus.acs_en),   32'd0);
    checkOutput("midrst.step_cnt", 32'(bus.step_cnt), 32'd0);
    checkOutput("midrst.sh_data",  32'(bus.sh_data),  32'd0);
    checkOutput("midrst.sym_sel",  32'(bus.sym_sel),  32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int stray_done = 0;
      int stray_busy = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        #1;
        if (bus.frame_done) stray_done++;
        if (bus.busy) stray_busy++;
      end
      checkOutput("midrst.no_done", 32'(stray_done), 32'd0);
      checkOutput("midrst.no_busy", 32'(stray_busy), 32'd0);
    end
    @(negedge clk);
    applyStimulus(vecs[5]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
